// File: rtl/cache_line_fill_if.sv
// Memory-side request/response bus of the line-fill controller.
// Request: a transfer happens on a rising edge where memReqValid && memReqReady; valid and address stay stable until then.
// Response: memRespValid marks a beat on that edge; there is no backpressure, so every valid beat is taken.
interface cache_line_fill_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32
);
   logic              memReqValid;
   logic              memReqReady;
   logic [ADDR_W-1:0] memReqAddr;
   logic              memRespValid;
   logic [WORD_W-1:0] memRespData;

   modport master (
      output memReqValid,
      output memReqAddr,
      input  memReqReady,
      input  memRespValid,
      input  memRespData
   );

   modport slave (
      input  memReqValid,
      input  memReqAddr,
      output memReqReady,
      output memRespValid,
      output memRespData
   );
endinterface

// File: rtl/cache_line_fill.sv
// Miss-refill controller: one line-aligned memory read, eight beats into a line buffer,
// early forwarding of the critical word, then a single-cycle write into the data array.
module cache_line_fill #(
   parameter int WORD_W = 32,
   parameter int BEATS  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      missReq,
   input  logic [ADDR_W-1:0]         missAddr,
   output logic                      fillBusy,
   cache_line_fill_if.master         mem,
   output logic                      critWordValid,
   output logic [WORD_W-1:0]         critWord,
   output logic                      regWrite,
   output logic [ADDR_W-1:0]         fillAddr,
   output logic [WORD_W*BEATS-1:0]   lineData,
   output logic [1:0]                fillState
);

   localparam int BEAT_W     = $clog2(BEATS);
   localparam int OFF_LSB    = $clog2(WORD_W / 8);
   localparam int LINE_BYTES = WORD_W * BEATS / 8;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FILL  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t            state;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] offset;

   assign fillBusy  = (state != IDLE);
   assign fillState = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         beat            <= '0;
         offset          <= '0;
         mem.memReqValid <= 1'b0;
         mem.memReqAddr  <= '0;
         critWordValid   <= 1'b0;
         critWord        <= '0;
         regWrite        <= 1'b0;
         fillAddr        <= '0;
         lineData        <= '0;
      end else begin
         critWordValid <= 1'b0;
         regWrite      <= 1'b0;
         case (state)
            IDLE: begin
               if (missReq) begin
                  fillAddr        <= missAddr & ALIGN_MASK;
                  mem.memReqAddr  <= missAddr & ALIGN_MASK;
                  offset          <= missAddr[OFF_LSB +: BEAT_W];
                  mem.memReqValid <= 1'b1;
                  state           <= REQ;
               end
            end
            REQ: begin
               if (mem.memReqReady) begin
                  mem.memReqValid <= 1'b0;
                  beat            <= '0;
                  state           <= FILL;
               end
            end
            FILL: begin
               if (mem.memRespValid) begin
                  lineData[int'(beat)*WORD_W +: WORD_W] <= mem.memRespData;
                  if (beat == offset) begin
                     critWord      <= mem.memRespData;
                     critWordValid <= 1'b1;
                  end
                  // The counter parks on the last beat rather than wrapping.
                  if (beat == LAST_BEAT) begin
                     regWrite <= 1'b1;
                     state    <= WRITE;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            WRITE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_fill.sv
// Randomized bench for cache_line_fill: memory responder, transaction-level reference model,
// per-cycle output comparison and a few literal timing/data checks.
module tb_cache_line_fill;

   localparam int WORD_W = 32;
   localparam int BEATS  = 8;
   localparam int ADDR_W = 32;
   localparam int LINE_W = WORD_W * BEATS;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              reset;
   logic              missReq = 1'b0;
   logic [ADDR_W-1:0] missAddr = '0;
   logic              fillBusy;
   logic              critWordValid;
   logic [WORD_W-1:0] critWord;
   logic              regWrite;
   logic [ADDR_W-1:0] fillAddr;
   logic [LINE_W-1:0] lineData;
   logic [1:0]        fillState;

   cache_line_fill_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) mem ();

   cache_line_fill #(.WORD_W(WORD_W), .BEATS(BEATS), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .missReq       (missReq),
      .missAddr      (missAddr),
      .fillBusy      (fillBusy),
      .mem           (mem),
      .critWordValid (critWordValid),
      .critWord      (critWord),
      .regWrite      (regWrite),
      .fillAddr      (fillAddr),
      .lineData      (lineData),
      .fillState     (fillState)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // A fill is "busy", then "granted" once the request is taken; the beats received so far
   // live in exp_q, and the line is written when all BEATS are present.
   logic [WORD_W-1:0] exp_q[$];
   bit                m_busy, m_granted, m_pulse;
   logic [WORD_W-1:0] m_crit;
   logic [ADDR_W-1:0] m_fill_addr, m_req_addr;
   logic [LINE_W-1:0] m_line;
   int                m_off, m_idx;

   task model_clear();
      m_busy = 0; m_granted = 0; m_pulse = 0;
      m_crit = '0; m_fill_addr = '0; m_req_addr = '0; m_line = '0; m_off = 0;
      exp_q.delete();
   endtask

   task model_step();
      m_pulse = 0;
      if (!m_busy) begin
         if (missReq) begin
            m_busy      = 1;
            m_granted   = 0;
            m_fill_addr = missAddr - (missAddr % 32);
            m_req_addr  = m_fill_addr;
            m_off       = int'(missAddr % 32) / 4;
            exp_q.delete();
         end
      end else if (!m_granted) begin
         if (mem.memReqReady) m_granted = 1;
      end else if (exp_q.size() < BEATS) begin
         if (mem.memRespValid) begin
            m_idx = exp_q.size();
            if (m_idx == m_off) begin
               m_crit  = mem.memRespData;
               m_pulse = 1;
            end
            m_line[32*m_idx +: 32] = mem.memRespData;
            exp_q.push_back(mem.memRespData);
         end
      end else begin
         m_busy = 0;
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_clear();
         else begin
            cyc++;
            model_step();
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   int                crit_cyc = -1, wr_cyc = -1, wr_cnt = 0;
   logic [LINE_W-1:0] line_snap = '0;
   logic [ADDR_W-1:0] req_addr_snap = '0;

   initial begin
      forever begin
         @(negedge clk);
         check("fillBusy",      256'(fillBusy),        256'(m_busy));
         check("memReqValid",   256'(mem.memReqValid), 256'(m_busy && !m_granted));
         check("memReqAddr",    256'(mem.memReqAddr),  256'(m_req_addr));
         check("critWordValid", 256'(critWordValid),   256'(m_pulse));
         check("critWord",      256'(critWord),        256'(m_crit));
         check("regWrite",      256'(regWrite),        256'(m_busy && m_granted && exp_q.size() == BEATS));
         check("fillAddr",      256'(fillAddr),        256'(m_fill_addr));
         check("lineData",      lineData,              m_line);
         if (critWordValid === 1'b1) crit_cyc = cyc;
         if (mem.memReqValid === 1'b1) req_addr_snap = mem.memReqAddr;
         if (regWrite === 1'b1) begin
            wr_cyc    = cyc;
            wr_cnt++;
            line_snap = lineData;
         end
      end
   end

   // ---------------- memory responder ----------------
   int                ready_delay = 0;
   bit                rand_gaps = 0, dir_gaps = 0, spurious = 0, dir_data = 0;
   logic [WORD_W-1:0] data_base = '0;
   int                rsp_k = 0, beats_left = 0, hs_cnt = 0, wait_cnt = 0, last_beat_cyc = -1;
   bit                gap_done = 0;

   initial begin
      bit hs, gap;
      mem.memReqReady  = 1'b0;
      mem.memRespValid = 1'b0;
      mem.memRespData  = '0;
      forever begin
         @(posedge clk);
         hs = mem.memReqValid && mem.memReqReady && !reset;
         #2;
         if (hs) begin
            beats_left = BEATS;
            rsp_k      = 0;
            gap_done   = 0;
            hs_cnt++;
         end
         if (mem.memReqValid && !reset) begin
            wait_cnt++;
            mem.memReqReady = (wait_cnt > ready_delay);
         end else begin
            wait_cnt        = 0;
            mem.memReqReady = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         if (beats_left > 0) begin
            gap = rand_gaps ? ($urandom_range(0, 3) == 0)
                            : (dir_gaps && (rsp_k == 3 || rsp_k == 6) && !gap_done);
            if (gap) begin
               mem.memRespValid = 1'b0;
               mem.memRespData  = $urandom;
               gap_done         = 1;
            end else begin
               mem.memRespValid = 1'b1;
               mem.memRespData  = dir_data ? data_base + 32'(rsp_k) : $urandom;
               if (rsp_k == BEATS - 1) last_beat_cyc = cyc;
               rsp_k++;
               beats_left--;
               gap_done = 0;
            end
         end else begin
            mem.memRespValid = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem.memRespData  = $urandom;
         end
      end
   end

   // ---------------- driver tasks ----------------
   int t0 = 0;

   task tick();
      @(posedge clk);
      #3;
   endtask

   task do_miss(input logic [ADDR_W-1:0] addr, input bit hold);
      missReq  = 1'b1;
      missAddr = addr;
      t0       = cyc;
      if (!hold) begin
         tick();
         missReq  = 1'b0;
         missAddr = $urandom;
      end
   endtask

   task wait_write(input string name);
      int w0, n;
      w0 = wr_cnt;
      n  = 0;
      while (wr_cnt == w0 && n < 200) begin
         tick();
         n++;
      end
      if (wr_cnt == w0) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout: no regWrite within %0d cycles", name, n);
      end
   endtask

   task set_rsp(input int rd, input bit rg, input bit dg, input bit sp, input bit dd, input logic [WORD_W-1:0] base);
      ready_delay = rd; rand_gaps = rg; dir_gaps = dg; spurious = sp; dir_data = dd; data_base = base;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [LINE_W-1:0] exp_line;
      int w0, h0, n;
      reset = 1'b1;
      set_rsp(0, 0, 0, 1, 0, '0);
      // reset with inputs toggling
      repeat (6) begin
         tick();
         missReq  = 1'($urandom_range(0, 1));
         missAddr = $urandom;
      end
      missReq = 1'b0;
      tick();
      reset = 1'b0;
      spurious = 0;
      tick();
      check("t1_no_req",   256'(mem.memReqValid), 256'(0));
      check("t1_not_busy", 256'(fillBusy),        256'(0));
      repeat (3) tick();

      // back-to-back fill, critical word at offset 5
      set_rsp(0, 0, 0, 0, 1, 32'hA0);
      crit_cyc = -1; wr_cyc = -1;
      do_miss(32'h0000_1234, 0);
      wait_write("t2");
      check("t2_req_addr",    256'(req_addr_snap),   256'(32'h0000_1220));
      check("t2_crit_cycle",  256'(crit_cyc - t0),   256'(8));
      check("t2_write_cycle", 256'(wr_cyc - t0),     256'(10));
      check("t2_crit_word",   256'(critWord),        256'(32'hA5));
      check("t2_line_lo",     256'(line_snap[31:0]), 256'(32'hA0));
      check("t2_line_hi",     256'(line_snap[255:224]), 256'(32'hA7));
      check("t2_fill_addr",   256'(fillAddr),        256'(32'h0000_1220));
      repeat (3) tick();

      // delayed ready and response gaps
      set_rsp(4, 0, 1, 0, 1, 32'hC0);
      w0 = wr_cnt; h0 = hs_cnt;
      do_miss(32'h0000_8008, 0);
      wait_write("t3");
      repeat (5) tick();
      exp_line = '0;
      for (int i = 0; i < BEATS; i++) exp_line[32*i +: 32] = 32'hC0 + 32'(i);
      check("t3_line",        line_snap,                 exp_line);
      check("t3_write_after", 256'(wr_cyc - last_beat_cyc), 256'(1));
      check("t3_one_write",   256'(wr_cnt - w0),         256'(1));
      check("t3_one_req",     256'(hs_cnt - h0),         256'(1));

      // missReq held high, spurious responses outside the fill
      set_rsp(2, 0, 0, 1, 1, 32'hD0);
      h0 = hs_cnt;
      do_miss(32'h0000_0040, 1);
      wait_write("t4a");
      check("t4_one_req", 256'(hs_cnt - h0),      256'(1));
      check("t4_line_lo", 256'(line_snap[31:0]),  256'(32'hD0));
      tick();
      missReq = 1'b0;
      wait_write("t4b");
      check("t4_two_req", 256'(hs_cnt - h0), 256'(2));
      spurious = 0;
      repeat (4) tick();

      // offset 7: critical word and line write coincide
      set_rsp(1, 0, 0, 0, 1, 32'hB0);
      crit_cyc = -1; wr_cyc = -2;
      do_miss(32'h0000_201C, 0);
      wait_write("t5");
      check("t5_coincide",  256'(crit_cyc), 256'(wr_cyc));
      check("t5_crit_word", 256'(critWord), 256'(32'hB7));
      repeat (3) tick();

      // reset after beat 4
      set_rsp(0, 0, 0, 0, 1, 32'hE0);
      w0 = wr_cnt;
      do_miss(32'h0000_3008, 0);
      n = 0;
      while (rsp_k != 5 && n < 100) begin
         tick();
         n++;
      end
      if (rsp_k != 5) begin
         errors++;
         checks++;
         $display("FAIL t6_beat4_timeout: rsp_k=%0d", rsp_k);
      end
      tick();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      n = 0;
      while (beats_left != 0 && n < 50) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check("t6_no_write", 256'(wr_cnt - w0), 256'(0));
      check("t6_idle",     256'(fillBusy),    256'(0));
      set_rsp(0, 0, 0, 0, 1, 32'hF0);
      do_miss(32'h0000_300C, 0);
      wait_write("t6b");
      check("t6_line_lo",   256'(line_snap[31:0]),    256'(32'hF0));
      check("t6_line_hi",   256'(line_snap[255:224]), 256'(32'hF7));
      check("t6_crit_word", 256'(critWord),           256'(32'hF3));
      repeat (3) tick();

      // randomized fills
      for (int f = 0; f < 30; f++) begin
         set_rsp($urandom_range(0, 5), 1, 0, 1'($urandom_range(0, 1)), 0, '0);
         do_miss($urandom, 1'($urandom_range(0, 1)));
         wait_write("rand");
         missReq = 1'b0;
         repeat ($urandom_range(1, 4)) tick();
      end
      spurious = 0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cache_line_fill.md
# cache_line_fill

Miss-refill controller sitting directly upstream of the 256-bit cache data array. On a miss it issues one line-aligned read request to memory, then collects eight 32-bit response beats into a 32-byte line buffer. It then pulses a one-cycle write enable so the data array latches the whole line. The requested (critical) word is forwarded to the pipeline as soon as its beat arrives.

## Interface
- WORD_W, 32, memory beat width in bits
- BEATS, 8, beats per line; line width = WORD_W*BEATS = 256
- ADDR_W, 32, byte address width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- missReq  in  1  start a fill; sampled only in IDLE
- missAddr  in  ADDR_W  byte address of the missing access
- fillBusy  out  1  high whenever state != IDLE
- memReqValid  out  1  read request valid
- memReqReady  in  1  memory accepts request
- memReqAddr  out  ADDR_W  line-aligned address (bits [4:0] = 0)
- memRespValid  in  1  response beat valid (no backpressure)
- memRespData  in  WORD_W  response beat data, ascending word order
- critWordValid  out  1  one-cycle pulse: critical word available
- critWord  out  WORD_W  critical word, held until next fill
- regWrite  out  1  one-cycle write enable to cache data array
- fillAddr  out  ADDR_W  line-aligned address of the line being written
- lineData  out  256  assembled line; beat k occupies [32k+31:32k]; byte 0 of line in [7:0]

## Operation
- States: IDLE, REQ, FILL, WRITE.
- IDLE: on missReq=1, register fillAddr = missAddr with [4:0] cleared and offset = missAddr[4:2]. Go to REQ. missReq is ignored in every other state; there is no queueing.
- REQ: memReqValid=1 and memReqAddr=fillAddr, both held stable until memReqReady=1. On handshake, clear beat counter to 0 and go to FILL.
- FILL: each cycle with memRespValid=1, write memRespData into lineData[32*beat +: 32] and increment beat. When the accepted beat index equals offset, load critWord and pulse critWordValid the following cycle. Gaps (memRespValid=0) are allowed and hold all state. Accepting beat 7 moves to WRITE.
- WRITE: regWrite=1 for exactly one cycle with lineData and fillAddr stable. Unconditional return to IDLE.
- memRespValid outside FILL is ignored. Responses after beat 7 are never consumed.
- Beat counter is 3 bits and never wraps within a fill; it clears only on the REQ->FILL transition and on reset.
- lineData, fillAddr, critWord hold their values after WRITE until overwritten by the next fill.
- Reset asserted in any state (including mid-FILL) forces IDLE immediately. Any partially collected line is discarded and no regWrite is issued. Memory-side beats that arrive after reset is released are ignored because the state is not FILL.

## Timing
- Reset values: fillBusy=0, memReqValid=0, memReqAddr=0, critWordValid=0, critWord=0, regWrite=0, fillAddr=0, lineData=0; state IDLE, beat=0.
- missReq sampled at cycle 0 -> memReqValid=1 and fillBusy=1 from cycle 1.
- Handshake at cycle r -> first beat may be accepted at cycle r+1.
- Beat accepted at cycle b -> lineData updated visible at b+1. If b is the critical beat, critWordValid=1 at b+1.
- Beat 7 accepted at cycle n -> regWrite=1 at n+1, fillBusy=0 at n+2.
- Minimum miss-to-write latency with ready and back-to-back beats: missReq at 0, ready at 1, beats at 2..9, regWrite at 10.
- Next missReq is accepted no earlier than cycle 11, the first cycle in IDLE after WRITE.
- Offset 7: critWordValid and regWrite are asserted in the same cycle.

## Test plan
- Reset with all inputs toggling -> every output 0; missReq during reset produces no memReqValid.
- missAddr=0x0000_1234, ready same cycle, beats 0xA0..0xA7 back-to-back -> memReqAddr=0x0000_1220. critWord=0xA5 with critWordValid at cycle 8. regWrite at cycle 10 with lineData[31:0]=0xA0 and [255:224]=0xA7. fillAddr=0x0000_1220.
- memReqReady delayed 4 cycles and memRespValid gaps after beats 2 and 5 -> memReqAddr stable throughout REQ. Line assembled correctly; regWrite the cycle after the final beat; exactly one regWrite.
- missReq held high through a whole fill, plus spurious memRespValid in IDLE/REQ -> only one request issued. Spurious beats not captured; second fill starts only from IDLE after WRITE.
- Offset 7 (missAddr=0x...1C) -> critWordValid and regWrite coincide in the same cycle, and critWord equals beat 7.
- Reset asserted after beat 4 -> immediate IDLE and no regWrite. Remaining beats ignored; a new miss then fills correctly from beat 0.
